// File: rtl/rq_ack_pkg.sv
// Shared definitions for the request-acknowledge responder: state encoding,
// request payload field offsets and the wait-configuration width.
package rq_ack_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] BUSY_ENC = 2'd1;
    localparam logic [1:0] ACK_ENC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        BUSY = BUSY_ENC,
        ACK  = ACK_ENC
    } state_t;

    localparam int unsigned WAIT_W    = 4;
    localparam int unsigned WDATA_LSB = 0;

    // Address field sits directly above the write data.
    function automatic int unsigned addr_lsb(input int unsigned dw);
        return dw;
    endfunction

    // Write-enable is the payload MSB.
    function automatic int unsigned we_pos(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/rq_ack_regmem.sv
// Register-array backing store for the responder: synchronous write,
// combinational read, asynchronous clear of every word.
module rq_ack_regmem #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/rq_ack_responder.sv
// Target end of the request-acknowledge link with per-request wait states.
// Optional checker enabled by RQ_ACK_RESP_PROTOCOL_CHECK_EN.
module rq_ack_responder
    import rq_ack_pkg::*;
#(
    parameter  int unsigned AW     = 4,
    parameter  int unsigned DW     = 8,
    localparam int unsigned REQ_DW = 1 + AW + DW,
    localparam int unsigned ACK_DW = DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [REQ_DW-1:0] req_data,
    output logic              ack,
    output logic [ACK_DW-1:0] ack_data,
    input  logic [WAIT_W-1:0] wait_cfg,
    output logic              busy,
    output logic              proto_err
);

    localparam int unsigned WE_POS   = we_pos(AW, DW);
    localparam int unsigned ADDR_LSB = addr_lsb(DW);

    state_t            state, state_nx;
    logic [WAIT_W-1:0] cnt, cnt_nx;
    logic              cap_we, cap_we_nx;
    logic [AW-1:0]     cap_addr, cap_addr_nx;
    logic [DW-1:0]     cap_wdata, cap_wdata_nx;
    logic              ack_nx;
    logic [ACK_DW-1:0] ack_data_nx;
    logic              busy_nx;
    logic              access;

    logic              in_we;
    logic [AW-1:0]     in_addr;
    logic [DW-1:0]     in_wdata;
    logic              acc_we;
    logic [AW-1:0]     acc_addr;
    logic [DW-1:0]     acc_wdata;
    logic [DW-1:0]     rdata;

    assign in_we    = req_data[WE_POS];
    assign in_addr  = req_data[ADDR_LSB +: AW];
    assign in_wdata = req_data[WDATA_LSB +: DW];

    // Zero-wait requests access straight from the bus; waited ones from the capture.
    assign acc_we    = (state == IDLE) ? in_we    : cap_we;
    assign acc_addr  = (state == IDLE) ? in_addr  : cap_addr;
    assign acc_wdata = (state == IDLE) ? in_wdata : cap_wdata;

    rq_ack_regmem #(
        .AW (AW),
        .DW (DW)
    ) u_regmem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (access & acc_we),
        .addr    (acc_addr),
        .wdata   (acc_wdata),
        .rdata_c (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            ack       <= 1'b0;
            ack_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cap_we    <= cap_we_nx;
            cap_addr  <= cap_addr_nx;
            cap_wdata <= cap_wdata_nx;
            ack       <= ack_nx;
            ack_data  <= ack_data_nx;
            busy      <= busy_nx;
        end
    end

    // Next-state, wait counter and registered-output preparation.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        cap_we_nx    = cap_we;
        cap_addr_nx  = cap_addr;
        cap_wdata_nx = cap_wdata;
        access       = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    cap_we_nx    = in_we;
                    cap_addr_nx  = in_addr;
                    cap_wdata_nx = in_wdata;
                    if (wait_cfg == '0) begin
                        access   = 1'b1;
                        state_nx = ACK;
                    end else begin
                        cnt_nx   = wait_cfg;
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt == WAIT_W'(1)) begin
                    cnt_nx   = '0;
                    access   = 1'b1;
                    state_nx = ACK;
                end else begin
                    cnt_nx = cnt - WAIT_W'(1);
                end
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        ack_nx      = access;
        ack_data_nx = access ? (acc_we ? acc_wdata : rdata) : '0;
        busy_nx     = (state_nx != IDLE);
    end

`ifdef RQ_ACK_RESP_PROTOCOL_CHECK_EN
    // Sticky flag for a withdrawn or unstable request during wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (state == BUSY) begin
            if (!req) begin
                proto_err <= 1'b1;
                $display("%m: protocol violation, req withdrawn before ack at %0t", $time);
            end else if (req_data != {cap_we, cap_addr, cap_wdata}) begin
                proto_err <= 1'b1;
                $display("%m: protocol violation, req_data changed while pending at %0t", $time);
            end
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: doc/rq_ack_responder.md
Name: rq_ack_responder

Overview:
- Receiver (target) end of the request-acknowledge protocol: accepts requests from an initiator, serves them from a small internal register memory, and returns a one-cycle ack pulse with response data.
- Wait states are programmable per request, so a bench can stress initiator and monitor timing.
- Sits opposite any initiator on the same interface; a protocol monitor may sit on the link in parallel.

Parameters:
- AW, 4, address width; memory depth = 2**AW words.
- DW, 8, data word width (1..32).
- REQ_DW, 1+AW+DW, request payload width; fixed by AW/DW and must not be overridden independently.
- ACK_DW, DW, response payload width.

Ports:
- clk, input, 1, clock, rising-edge active.
- rst_n, input, 1, reset, asynchronous, active-low.
- req, input, 1, request; held high by the initiator until acknowledged.
- req_data, input, REQ_DW, {we[REQ_DW-1], addr[AW+DW-1:DW], wdata[DW-1:0]}; stable while req=1 and not yet acknowledged.
- ack, output, 1, acknowledge, single-cycle pulse.
- ack_data, output, ACK_DW, response data; valid only when ack=1, 0 otherwise.
- wait_cfg, input, 4, extra wait cycles W inserted before ack; sampled at request capture.
- busy, output, 1, high in BUSY and ACK states.
- proto_err, output, 1, sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, ack=0, ack_data=0, busy=0, proto_err=0, counter=0.
  - All memory words cleared to 0.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - On req=1, capture we/addr/wdata and W=wait_cfg.
  - If W=0, perform access and go to ACK. Otherwise load cnt=W and go to BUSY.
- BUSY:
  - Decrement cnt each cycle.
  - At the edge where cnt==1, perform access and go to ACK.
- Access, done on the edge that enters ACK:
  - Write (we=1): mem[addr]<=wdata; ack_data<=wdata.
  - Read (we=0): ack_data<=mem[addr].
  - ack<=1 on the same edge.
- ACK:
  - ack=1 for exactly one cycle; req is ignored during this cycle.
  - Next edge: ack<=0, ack_data<=0, go to IDLE.
- Latency: req first sampled high in cycle n gives ack=1 in cycle n+1+W.
  - ack never coincides with the first cycle of req.
  - ack is never asserted while req=0.
- Back-to-back:
  - If req stays high in cycle n+2+W, that cycle starts a new request (new capture).
  - Minimum request spacing is 2 cycles.
  - Read-after-write to the same address returns the written data.
- Request withdrawn (req=0 in BUSY):
  - Abort: return to IDLE, no ack, no memory write.
  - Set proto_err only if the macro is enabled.
- wait_cfg changes after capture have no effect on the request in flight.
- Address wraps naturally; every AW-bit value is valid.
- Reset asserted mid-operation: the request is dropped immediately, no ack, state and memory reset.

Optional Feature:
- Macro: RQ_ACK_RESP_PROTOCOL_CHECK_EN.
- With the macro defined:
  - In BUSY, set proto_err (sticky until reset) and print a $display message with %M and $time when req drops before ack.
  - Same action when req_data differs from the captured value while in BUSY.
- Without the macro: proto_err is tied to 0 and no check logic or messages are compiled.

Decomposition:
- Shared package rq_ack_pkg:
  - State encoding localparams (IDLE=2'd0, BUSY=2'd1, ACK=2'd2).
  - Field-offset constants for we/addr/wdata within req_data.
  - Wait-config width constant (4).
- One natural sub-module: rq_ack_regmem (2**AW x DW register array, synchronous write, combinational read, async clear).
- FSM and counter stay in the top module.

Test Plan:
- Reset then write: req=1, req_data={1,4'h3,8'hA5}, W=0 -> ack=1 exactly one cycle after req first high, ack_data=8'hA5, ack=0 next cycle.
- Read-back back-to-back: keep req=1 after the ack of the write above with {0,4'h3,8'h00} -> second ack 2 cycles after the first, ack_data=8'hA5.
- Wait states: W=5, read of address 4'h0 after reset -> ack in cycle n+6, ack_data=8'h00, busy=1 for cycles n+1..n+6.
- Withdrawal: W=3, drop req after 2 cycles -> no ack, mem unchanged, state IDLE; proto_err=1 with the macro, 0 without.
- Reset mid-request: W=7, assert rst_n=0 at cycle n+3 -> ack stays 0, memory cleared, next request served normally with read data 0.
- Monitor run: 200 random requests with random W and random gaps -> parallel protocol monitor reports zero errors; ack_data matches a reference memory model.
